// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed memory responder with a fixed, parameterised
//               response latency. Misaligned or out-of-range accesses are
//               flagged with err instead of being performed.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH   = 256,  // 32-bit words, power of two, 2..4096
  parameter int LATENCY = 2     // request-to-response cycles, 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  counter;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        accept;
  logic        enter_resp;

  // Request being serviced at the edge that enters RESP. With LATENCY=1 the
  // access happens at the acceptance edge itself, so the live inputs are used;
  // otherwise RESP is always entered from WAIT and the latched copy is used.
  logic             acc_wr;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_data;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;

  // Storage is not touched by reset; it only starts out cleared.
  logic [31:0] mem [DEPTH] = '{default: '0};

  // Select between latched and live request fields, and check the address
  always_comb begin
    acc_wr   = (state == WAIT) ? lat_wr   : wr;
    acc_addr = (state == WAIT) ? lat_addr : address;
    acc_data = (state == WAIT) ? lat_data : datain;
    acc_err  = (|acc_addr[1:0]) | (|acc_addr[31:IDX_W+2]);
    acc_idx  = acc_addr[IDX_W+1:2];
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        // <= rather than == so a corrupted counter can never lock the FSM
        if (counter <= 4'd1) begin
          next_state = RESP;
        end
      end
      RESP: begin
        ready = 1'b1;
        if (req) begin
          accept     = 1'b1;
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP);
  end

  // Request latches, latency counter and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter  <= 4'd0;
      lat_wr   <= 1'b0;
      lat_addr <= 32'd0;
      lat_data <= 32'd0;
      dataout  <= 32'd0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        lat_wr   <= wr;
        lat_addr <= address;
        lat_data <= datain;
        counter  <= LAT_M1;
      end else if (state == WAIT) begin
        counter <= counter - 4'd1;
      end
      if (enter_resp) begin
        err <= acc_err;
        if (acc_err) begin
          dataout <= 32'd0;
        end else if (acc_wr) begin
          dataout <= acc_data;
        end else begin
          dataout <= mem[acc_idx];
        end
      end else begin
        err <= 1'b0;
      end
    end
  end

  // Storage write; gated by reset so a write pending during reset is dropped
  always_ff @(posedge clock) begin
    if (enter_resp && acc_wr && !acc_err && !reset) begin
      mem[acc_idx] <= acc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. Instance A uses
//               LATENCY=2, instance B uses LATENCY=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic        rst_a, req_a, wr_a, ready_a, busy_a, err_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic        rst_b, req_b, wr_b, ready_b, busy_b, err_b;
  logic [31:0] addr_b, din_b, dout_b;
  logic        busy_b_seen = 1'b0;

  mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
    .clock(clk), .reset(rst_a), .req(req_a), .wr(wr_a), .address(addr_a),
    .datain(din_a), .dataout(dout_a), .ready(ready_a), .busy(busy_a), .err(err_a)
  );

  mem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (
    .clock(clk), .reset(rst_b), .req(req_b), .wr(wr_b), .address(addr_b),
    .datain(din_b), .dataout(dout_b), .ready(ready_b), .busy(busy_b), .err(err_b)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single checked comparison
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor for instance A: every ready pops one expected response
  always @(negedge clk) begin
    exp_t e;
    if (ready_a === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_ready cyc=%0d dataout=%h err=%b", cyc, dout_a, err_a);
      end else begin
        e = qa.pop_front();
        if (dout_a !== e.data || err_a !== e.err || cyc != e.cyc) begin
          bad++;
          $display("FAIL a_resp actual data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                   dout_a, err_a, cyc, e.data, e.err, e.cyc);
        end
      end
    end else if (err_a !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL a_err_outside_resp actual=%b required=0 cyc=%0d", err_a, cyc);
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    exp_t e;
    if (busy_b === 1'b1) busy_b_seen = 1'b1;
    if (ready_b === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_ready cyc=%0d dataout=%h err=%b", cyc, dout_b, err_b);
      end else begin
        e = qb.pop_front();
        if (dout_b !== e.data || err_b !== e.err || cyc != e.cyc) begin
          bad++;
          $display("FAIL b_resp actual data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                   dout_b, err_b, cyc, e.data, e.err, e.cyc);
        end
      end
    end
  end

  // Drive one cycle of request on A; optionally push its expected response
  task automatic a_req(input logic w, input logic [31:0] ad, input logic [31:0] dat,
                       input logic push, input logic [31:0] ed, input logic ee);
    exp_t e;
    req_a = 1'b1; wr_a = w; addr_a = ad; din_a = dat;
    if (push) begin
      e.data = ed; e.err = ee; e.cyc = cyc + 2;
      qa.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic a_idle(input int n);
    req_a = 1'b0; wr_a = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic b_req(input logic w, input logic [31:0] ad, input logic [31:0] dat,
                       input logic [31:0] ed);
    exp_t e;
    req_b = 1'b1; wr_b = w; addr_b = ad; din_b = dat;
    e.data = ed; e.err = 1'b0; e.cyc = cyc + 1;
    qb.push_back(e);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    rst_a = 1'b1; req_a = 1'b0; wr_a = 1'b0; addr_a = '0; din_a = '0;
    rst_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_a_outputs", {dout_a[31:3], dout_a[2:0] | {ready_a, busy_a, err_a}}, 32'd0);
    chk("reset_b_outputs", {dout_b[31:3], dout_b[2:0] | {ready_b, busy_b, err_b}}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // 1: write then busy / ready / idle with held data
    a_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("t1_busy", {31'd0, busy_a}, 32'd1);
    chk("t1_not_ready", {31'd0, ready_a}, 32'd0);
    a_idle(2);
    chk("t1_idle_busy_ready", {30'd0, busy_a, ready_a}, 32'd0);
    chk("t1_dataout_held", dout_a, 32'hDEADBEEF);

    // 2: read back, then read of an unwritten word
    a_req(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0); a_idle(2);
    a_req(1'b0, 32'h14, 32'h0, 1'b1, 32'h0, 1'b0);        a_idle(2);

    // 3: errors; write to out-of-range 0x400 must not alias onto word 0
    a_req(1'b1, 32'h0,   32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0); a_idle(2);
    a_req(1'b0, 32'h13,  32'h0,        1'b1, 32'h0, 1'b1);        a_idle(2);
    a_req(1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);        a_idle(2);
    a_req(1'b0, 32'h400, 32'h0,        1'b1, 32'h0, 1'b1);        a_idle(2);
    a_req(1'b1, 32'h12,  32'h12345678, 1'b1, 32'h0, 1'b1);        a_idle(2);
    a_req(1'b0, 32'h0,   32'h0,        1'b1, 32'hA5A5A5A5, 1'b0); a_idle(2);
    a_req(1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0); a_idle(2);

    // 4: back-to-back with req held; WAIT-cycle requests are ignored
    a_req(1'b1, 32'h20, 32'h1,  1'b1, 32'h1, 1'b0);
    a_req(1'b1, 32'h28, 32'h99, 1'b0, 32'h0, 1'b0);
    a_req(1'b1, 32'h24, 32'h2,  1'b1, 32'h2, 1'b0);
    a_req(1'b1, 32'h2C, 32'h77, 1'b0, 32'h0, 1'b0);
    a_req(1'b0, 32'h20, 32'h0,  1'b1, 32'h1, 1'b0);
    a_req(1'b1, 32'h20, 32'h55, 1'b0, 32'h0, 1'b0);
    a_idle(2);
    a_req(1'b0, 32'h28, 32'h0, 1'b1, 32'h0, 1'b0); a_idle(2);
    a_req(1'b0, 32'h2C, 32'h0, 1'b1, 32'h0, 1'b0); a_idle(2);
    a_req(1'b0, 32'h24, 32'h0, 1'b1, 32'h2, 1'b0); a_idle(2);
    a_req(1'b0, 32'h20, 32'h0, 1'b1, 32'h1, 1'b0); a_idle(2);

    // 6: reset during WAIT aborts the write
    a_req(1'b1, 32'h30, 32'h11, 1'b1, 32'h11, 1'b0); a_idle(2);
    a_req(1'b1, 32'h30, 32'h55, 1'b0, 32'h0, 1'b0);
    chk("t6_in_wait", {31'd0, busy_a}, 32'd1);
    req_a = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("t6_async_dataout", dout_a, 32'd0);
    chk("t6_async_flags", {29'd0, ready_a, busy_a, err_a}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    a_idle(3);
    a_req(1'b0, 32'h30, 32'h0, 1'b1, 32'h11, 1'b0); a_idle(2);

    // 5: LATENCY=1 continuous stream of writes then reads
    b_req(1'b1, 32'h0, 32'h100, 32'h100);
    b_req(1'b1, 32'h4, 32'h101, 32'h101);
    b_req(1'b1, 32'h8, 32'h102, 32'h102);
    b_req(1'b1, 32'hC, 32'h103, 32'h103);
    b_req(1'b0, 32'h0, 32'h0,   32'h100);
    b_req(1'b0, 32'h4, 32'h0,   32'h101);
    b_req(1'b0, 32'h8, 32'h0,   32'h102);
    b_req(1'b0, 32'hC, 32'h0,   32'h103);
    req_b = 1'b0;
    @(negedge clk);
    chk("t5_ready_drops", {31'd0, ready_b}, 32'd0);

    // Drain with a bound, then final checks
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    chk("b_busy_never", {31'd0, busy_b_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
